caliptra_fpga_itrng_feeder: RTL and testbench
=============================================

CALIPTRA_FPGA_ITRNG_FEEDER -- requirements
Module: caliptra_fpga_itrng_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO capacity in 32-bit entropy words (power of 2, >=2).
REQ-002 SHALL have parameter NIBBLE_GAP, default 0, meaning idle cycles inserted between consecutive nibbles.
REQ-003 SHALL have port aclk_gated  input  1  gated core clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push_req  input  1  host push toggle; new word offered when push_req != push_ack.
REQ-006 SHALL have port push_data  input  32  entropy word; stable while push_req != push_ack.
REQ-007 SHALL have port push_ack  output  1  copy of push_req once the offered word is consumed.
REQ-008 SHALL have port flush_req  input  1  flush toggle; flush requested when flush_req != flush_ack.
REQ-009 SHALL have port flush_ack  output  1  copy of flush_req once the flush is done.
REQ-010 SHALL have port etrng_req  input  1  core entropy request, level.
REQ-011 SHALL have port itrng_data  output  4  entropy nibble to the core.
REQ-012 SHALL have port itrng_valid  output  1  itrng_data valid this cycle.
REQ-013 SHALL have port fifo_level  output  $clog2(DEPTH)+1  words currently stored.
REQ-014 SHALL have port overflow  output  1  sticky: a push was dropped because the FIFO was full.
REQ-015 SHALL have port underflow  output  1  sticky: etrng_req high in IDLE with the FIFO empty.

Function
REQ-016 Toggle inputs SHALL be sampled directly, without synchronisers: they come from registers on the ungated parent clock and stay stable while aclk_gated is stopped.
REQ-017 Push: on an edge with push_req != push_ack, SHALL store push_data if not full and set push_ack = push_req on that same edge.
REQ-018 Push while full: word SHALL be dropped, overflow set, push_ack still updated; a simultaneous pop frees a slot, the push is accepted, and overflow is not set.
REQ-019 FIFO SHALL be circular with pointers wrapping modulo DEPTH; fifo_level SHALL equal pushes minus pops, saturating at DEPTH and 0.
REQ-020 FSM states SHALL be IDLE, SEND, GAP.
REQ-021 IDLE: with etrng_req=1 and level>0, SHALL pop the head word into a 32-bit shift register, clear nib_cnt, and enter SEND.
REQ-022 IDLE: with etrng_req=1 and level=0, SHALL set underflow and stay in IDLE.
REQ-023 SEND: itrng_valid=1 and itrng_data=shreg[3:0]; on each edge the shift register shifts right by 4 and nib_cnt increments, so nibbles go out LSB first.
REQ-024 SEND after nibble 0..6: if NIBBLE_GAP>0, SHALL enter GAP for exactly NIBBLE_GAP cycles (itrng_valid=0) and then return to SEND; otherwise stay in SEND.
REQ-025 SEND after nibble 7: with etrng_req=1 and level>0 (and NIBBLE_GAP=0), SHALL pop the next word and stay in SEND back-to-back; otherwise enter GAP, then IDLE.
REQ-026 etrng_req deasserting mid-word SHALL NOT truncate the word: all 8 nibbles are delivered, then the FSM returns to IDLE.
REQ-027 Pop latency: the pop edge SHALL be followed immediately by itrng_valid=1 in the next cycle; itrng_data and itrng_valid SHALL be registered.
REQ-028 Flush: on an edge with flush_req != flush_ack, SHALL empty the FIFO, clear overflow and underflow, force IDLE with itrng_valid=0, and set flush_ack = flush_req.
REQ-029 Flush has priority over pop; a push on the same edge as a flush SHALL be applied after the flush, leaving level=1.

Reset
REQ-030 On rstn low, SHALL asynchronously set: state IDLE, pointers 0, fifo_level 0, itrng_valid 0, itrng_data 0, push_ack 0, flush_ack 0, overflow 0, underflow 0.
REQ-031 Reset mid-word SHALL abandon the partial word; no nibble is emitted until a new pop.
REQ-032 FIFO storage contents SHALL NOT be reset.

Verification
REQ-033 Push 0x87654321, hold etrng_req=1, NIBBLE_GAP=0 -> itrng_valid high for 8 consecutive cycles with data 1,2,3,4,5,6,7,8; level 1->0; push_ack toggles.
REQ-034 Push 17 words with DEPTH=16 and etrng_req=0 -> level=16, overflow=1, 17th word absent from the drained stream.
REQ-035 etrng_req=1 with the FIFO empty -> underflow=1, itrng_valid stays 0; a following flush toggle -> underflow=0, flush_ack matches flush_req.
REQ-036 NIBBLE_GAP=2, one word pushed -> valid nibbles spaced 3 cycles apart, 8 nibbles over 22 cycles.
REQ-037 Two words pushed, etrng_req dropped after nibble 3 -> first word completes (8 nibbles), second word stays (level=1).
REQ-038 Assert rstn low during nibble 5 -> itrng_valid=0 immediately, level=0, all acks and stickies 0.

Source files
------------

// File: rtl/caliptra_fpga_itrng_feeder.sv
// Buffers host-pushed 32-bit entropy words in a circular FIFO and serialises them
// LSB-first as 4-bit nibbles to the core's internal TRNG input on request.
module caliptra_fpga_itrng_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NIBBLE_GAP = 0
) (
    input  logic                   aclk_gated,
    input  logic                   rstn,
    input  logic                   push_req,
    input  logic [31:0]            push_data,
    output logic                   push_ack,
    input  logic                   flush_req,
    output logic                   flush_ack,
    input  logic                   etrng_req,
    output logic [3:0]             itrng_data,
    output logic                   itrng_valid,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned GW = (NIBBLE_GAP > 1) ? $clog2(NIBBLE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((NIBBLE_GAP > 0) ? NIBBLE_GAP - 1 : 0);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [2:0]    nib_cnt_q, nib_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          valid_q, valid_d;
    logic [3:0]    data_q, data_d;
    logic          push_ack_q, flush_ack_q;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          push_pend, flush_pend, fifo_empty, fifo_full, gap_done;
    logic          pop, wr_en;

    // Toggle handshakes are compared directly: the requesters live on the ungated clock.
    assign push_pend  = push_req != push_ack_q;
    assign flush_pend = flush_req != flush_ack_q;
    assign fifo_empty = level_q == '0;
    assign fifo_full  = level_q == FULL_LVL;
    assign gap_done   = (NIBBLE_GAP <= 1) || (gap_cnt_q == GAP_LAST);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        nib_cnt_d = nib_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unf_d     = unf_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (etrng_req) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_d   = mem_q[rd_ptr_q];
                        nib_cnt_d = 3'd0;
                        state_d   = SEND;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
            end
            SEND: begin
                shreg_d   = {4'h0, shreg_q[31:4]};
                nib_cnt_d = nib_cnt_q + 3'd1;
                if (nib_cnt_q == 3'd7) begin
                    if (etrng_req && !fifo_empty && (NIBBLE_GAP == 0)) begin
                        pop       = 1'b1;
                        shreg_d   = mem_q[rd_ptr_q];
                        nib_cnt_d = 3'd0;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end else if (NIBBLE_GAP > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                // nib_cnt wraps to 0 only after the last nibble of a word.
                if (gap_done) begin
                    state_d = (nib_cnt_q == 3'd0) ? IDLE : SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_pend) begin
            state_d = IDLE;
            pop     = 1'b0;
            unf_d   = 1'b0;
        end
        valid_d = state_d == SEND;
        data_d  = valid_d ? shreg_d[3:0] : 4'h0;
    end

    // A push during a flush lands in the freshly emptied FIFO at slot 0.
    always_comb begin
        wr_addr  = flush_pend ? '0 : wr_ptr_q;
        wr_en    = push_pend && (!fifo_full || pop || flush_pend);
        wr_ptr_d = flush_pend ? '0 : wr_ptr_q;
        rd_ptr_d = flush_pend ? '0 : rd_ptr_q;
        level_d  = flush_pend ? '0 : level_q;
        ovf_d    = flush_pend ? 1'b0 : ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en) begin
            wr_ptr_d = wr_addr + 1'b1;
        end
        if (wr_en && !pop) begin
            level_d = level_d + 1'b1;
        end else if (pop && !wr_en) begin
            level_d = level_d - 1'b1;
        end
        if (push_pend && !wr_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge aclk_gated or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            shreg_q     <= '0;
            nib_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            data_q      <= 4'h0;
            push_ack_q  <= 1'b0;
            flush_ack_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            shreg_q     <= shreg_d;
            nib_cnt_q   <= nib_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            push_ack_q  <= push_req;
            flush_ack_q <= flush_req;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge aclk_gated) begin
        if (wr_en) begin
            mem_q[wr_addr] <= push_data;
        end
    end

    assign push_ack    = push_ack_q;
    assign flush_ack   = flush_ack_q;
    assign itrng_data  = data_q;
    assign itrng_valid = valid_q;
    assign fifo_level  = level_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_caliptra_fpga_itrng_feeder.sv
// Directed bench for caliptra_fpga_itrng_feeder: instance A (no nibble gap) and
// instance B (NIBBLE_GAP=2), with a nibble scoreboard per instance.
module tb_caliptra_fpga_itrng_feeder;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic aclk_gated = 1'b0;
    logic rstn;
    always #5 aclk_gated = ~aclk_gated;

    logic          aPushReq, aFlushReq, aEtrngReq, aPushAck, aFlushAck, aValid, aOvf, aUnf;
    logic [31:0]   aPushData;
    logic [3:0]    aData;
    logic [LW-1:0] aLevel;
    logic          bPushReq, bFlushReq, bEtrngReq, bPushAck, bFlushAck, bValid, bOvf, bUnf;
    logic [31:0]   bPushData;
    logic [3:0]    bData;
    logic [LW-1:0] bLevel;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [3:0] expA[$];
    logic [3:0] expB[$];
    int bStamp[$];

    caliptra_fpga_itrng_feeder #(.DEPTH(DEPTH), .NIBBLE_GAP(0)) dutA (
        .aclk_gated (aclk_gated), .rstn (rstn),
        .push_req (aPushReq), .push_data (aPushData), .push_ack (aPushAck),
        .flush_req (aFlushReq), .flush_ack (aFlushAck), .etrng_req (aEtrngReq),
        .itrng_data (aData), .itrng_valid (aValid), .fifo_level (aLevel),
        .overflow (aOvf), .underflow (aUnf)
    );

    caliptra_fpga_itrng_feeder #(.DEPTH(DEPTH), .NIBBLE_GAP(2)) dutB (
        .aclk_gated (aclk_gated), .rstn (rstn),
        .push_req (bPushReq), .push_data (bPushData), .push_ack (bPushAck),
        .flush_req (bFlushReq), .flush_ack (bFlushAck), .etrng_req (bEtrngReq),
        .itrng_data (bData), .itrng_valid (bValid), .fifo_level (bLevel),
        .overflow (bOvf), .underflow (bUnf)
    );

    always @(posedge aclk_gated) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every valid nibble must match the head of the expected queue.
    always @(negedge aclk_gated) begin
        if (aValid === 1'b1) begin
            if (expA.size() == 0) checkOutput("a_extra_nibble", 32'(aValid), 32'd0);
            else checkOutput("a_nibble", 32'(aData), 32'(expA.pop_front()));
        end
        if (bValid === 1'b1) begin
            bStamp.push_back(cyc);
            if (expB.size() == 0) checkOutput("b_extra_nibble", 32'(bValid), 32'd0);
            else checkOutput("b_nibble", 32'(bData), 32'(expB.pop_front()));
        end
    end

    task automatic applyStimulus(input bit toB, input logic [31:0] word, input bit stored);
        if (toB) begin
            bPushData = word;
            bPushReq  = ~bPushReq;
        end else begin
            aPushData = word;
            aPushReq  = ~aPushReq;
        end
        @(negedge aclk_gated);
        if (toB) checkOutput("b_push_ack", 32'(bPushAck), 32'(bPushReq));
        else     checkOutput("a_push_ack", 32'(aPushAck), 32'(aPushReq));
        if (stored) begin
            for (int k = 0; k < 8; k++) begin
                if (toB) expB.push_back(word[4*k +: 4]);
                else     expA.push_back(word[4*k +: 4]);
            end
        end
    endtask

    task automatic applyFlush();
        aFlushReq = ~aFlushReq;
        @(negedge aclk_gated);
        checkOutput("a_flush_ack", 32'(aFlushAck), 32'(aFlushReq));
        checkOutput("a_flush_level", 32'(aLevel), 32'd0);
        checkOutput("a_flush_ovf", 32'(aOvf), 32'd0);
        checkOutput("a_flush_unf", 32'(aUnf), 32'd0);
        checkOutput("a_flush_valid", 32'(aValid), 32'd0);
        expA.delete();
    endtask

    // Requests one word, withdraws the request once it starts, then lets it finish.
    task automatic drainOne(input string tag);
        int n;
        n = 0;
        aEtrngReq = 1'b1;
        while (aValid !== 1'b1 && n < 12) begin
            @(negedge aclk_gated);
            n++;
        end
        aEtrngReq = 1'b0;
        repeat (10) @(negedge aclk_gated);
        checkOutput({tag, "_drained"}, 32'(expA.size()), 32'd0);
        checkOutput({tag, "_valid_idle"}, 32'(aValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [31:0] w;
        rstn = 1'b0;
        aPushReq = 1'b0; aFlushReq = 1'b0; aEtrngReq = 1'b0; aPushData = '0;
        bPushReq = 1'b0; bFlushReq = 1'b0; bEtrngReq = 1'b0; bPushData = '0;
        repeat (2) @(negedge aclk_gated);
        checkOutput("rst_valid", 32'(aValid), 32'd0);
        checkOutput("rst_data", 32'(aData), 32'd0);
        checkOutput("rst_level", 32'(aLevel), 32'd0);
        checkOutput("rst_push_ack", 32'(aPushAck), 32'd0);
        checkOutput("rst_flush_ack", 32'(aFlushAck), 32'd0);
        checkOutput("rst_ovf", 32'(aOvf), 32'd0);
        checkOutput("rst_unf", 32'(aUnf), 32'd0);
        checkOutput("rst_b_valid", 32'(bValid), 32'd0);
        rstn = 1'b1;
        @(negedge aclk_gated);

        // Single word, eight consecutive nibbles LSB first.
        applyStimulus(1'b0, 32'h87654321, 1'b1);
        checkOutput("a_level_pushed", 32'(aLevel), 32'd1);
        aEtrngReq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk_gated);
            checkOutput("a_valid_run", 32'(aValid), 32'd1);
            if (i == 0) checkOutput("a_level_popped", 32'(aLevel), 32'd0);
            if (i == 7) aEtrngReq = 1'b0;
        end
        @(negedge aclk_gated);
        checkOutput("a_valid_after_word", 32'(aValid), 32'd0);
        checkOutput("a_word_done", 32'(expA.size()), 32'd0);
        checkOutput("a_no_unf", 32'(aUnf), 32'd0);

        // Fill to capacity plus one dropped word, then drain back-to-back.
        for (int i = 0; i < 17; i++) begin
            w = {8'hA5, 8'(i), 8'(8'h3C + i), 8'(8'hC3 - i)};
            applyStimulus(1'b0, w, i < 16);
            if (i == 15) checkOutput("a_ovf_at_full", 32'(aOvf), 32'd0);
        end
        checkOutput("a_level_full", 32'(aLevel), 32'd16);
        checkOutput("a_ovf_set", 32'(aOvf), 32'd1);
        aEtrngReq = 1'b1;
        n = 0;
        while (expA.size() > 0 && n < 200) begin
            @(negedge aclk_gated);
            n++;
        end
        repeat (4) @(negedge aclk_gated);
        checkOutput("a_drain_all", 32'(expA.size()), 32'd0);
        checkOutput("a_level_empty", 32'(aLevel), 32'd0);
        checkOutput("a_unf_set", 32'(aUnf), 32'd1);
        checkOutput("a_ovf_sticky", 32'(aOvf), 32'd1);
        repeat (3) begin
            @(negedge aclk_gated);
            checkOutput("a_empty_no_valid", 32'(aValid), 32'd0);
        end
        aEtrngReq = 1'b0;
        applyFlush();

        // Request withdrawn mid-word: first word completes, second stays queued.
        applyStimulus(1'b0, 32'hDEADBEEF, 1'b1);
        applyStimulus(1'b0, 32'h0BADF00D, 1'b1);
        aEtrngReq = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge aclk_gated);
        aEtrngReq = 1'b0;
        repeat (8) @(negedge aclk_gated);
        checkOutput("a_partial_level", 32'(aLevel), 32'd1);
        checkOutput("a_partial_left", 32'(expA.size()), 32'd8);
        checkOutput("a_partial_valid", 32'(aValid), 32'd0);
        applyFlush();

        // Flush and push on the same edge leave exactly the new word.
        aFlushReq = ~aFlushReq;
        aPushData = 32'h2468ACE0;
        aPushReq  = ~aPushReq;
        @(negedge aclk_gated);
        checkOutput("a_fp_flush_ack", 32'(aFlushAck), 32'(aFlushReq));
        checkOutput("a_fp_push_ack", 32'(aPushAck), 32'(aPushReq));
        checkOutput("a_fp_level", 32'(aLevel), 32'd1);
        expA.delete();
        w = 32'h2468ACE0;
        for (int k = 0; k < 8; k++) expA.push_back(w[4*k +: 4]);
        drainOne("a_fp");

        // Reset during nibble 5 abandons the word.
        aEtrngReq = 1'b1;
        @(negedge aclk_gated);
        checkOutput("a_unf_before_rst", 32'(aUnf), 32'd1);
        applyStimulus(1'b0, 32'h0FEDCBA9, 1'b1);
        n = 0;
        while (aValid !== 1'b1 && n < 12) begin
            @(negedge aclk_gated);
            n++;
        end
        repeat (5) @(negedge aclk_gated);
        checkOutput("a_nibble5_valid", 32'(aValid), 32'd1);
        #2;
        rstn = 1'b0;
        aPushReq = 1'b0; aFlushReq = 1'b0; aEtrngReq = 1'b0;
        #1;
        checkOutput("a_arst_valid", 32'(aValid), 32'd0);
        checkOutput("a_arst_level", 32'(aLevel), 32'd0);
        checkOutput("a_arst_push_ack", 32'(aPushAck), 32'd0);
        checkOutput("a_arst_flush_ack", 32'(aFlushAck), 32'd0);
        checkOutput("a_arst_ovf", 32'(aOvf), 32'd0);
        checkOutput("a_arst_unf", 32'(aUnf), 32'd0);
        expA.delete();
        repeat (2) @(negedge aclk_gated);
        rstn = 1'b1;
        repeat (10) @(negedge aclk_gated);
        checkOutput("a_post_rst_valid", 32'(aValid), 32'd0);
        checkOutput("a_post_rst_level", 32'(aLevel), 32'd0);

        // NIBBLE_GAP=2: nibbles three cycles apart, 22 cycles per word.
        applyStimulus(1'b1, 32'h13579BDF, 1'b1);
        bEtrngReq = 1'b1;
        n = 0;
        while (bValid !== 1'b1 && n < 12) begin
            @(negedge aclk_gated);
            n++;
        end
        bEtrngReq = 1'b0;
        repeat (30) @(negedge aclk_gated);
        checkOutput("b_nibble_count", 32'(bStamp.size()), 32'd8);
        if (bStamp.size() == 8) begin
            for (int i = 1; i < 8; i++) checkOutput("b_spacing", 32'(bStamp[i] - bStamp[i-1]), 32'd3);
            checkOutput("b_span", 32'(bStamp[7] - bStamp[0] + 1), 32'd22);
        end
        checkOutput("b_drained", 32'(expB.size()), 32'd0);
        checkOutput("b_level", 32'(bLevel), 32'd0);
        checkOutput("b_unf", 32'(bUnf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
